// File: rtl/move_queue_pkg.sv
// move_queue_pkg: shared constants and types for the move queue.
//   - colour and piece codes, move-word field offsets
//   - lane index names for the 16 move directions
//   - FSM state encoding
//   - helpers that classify a move word as legal / capture
package move_queue_pkg;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  localparam logic [4:0] PAWN   = 5'b00010;
  localparam logic [4:0] KNIGHT = 5'b00001;
  localparam logic [4:0] BISHOP = 5'b01000;
  localparam logic [4:0] ROOK   = 5'b10000;
  localparam logic [4:0] QUEEN  = 5'b11000;
  localparam logic [4:0] KING   = 5'b00100;

  localparam int MOVE_W    = 32;
  localparam int NUM_LANES = 16;
  localparam int COUNT_W   = 5;
  localparam int FIELD_W   = 6;
  localparam int TYPE_W    = 5;
  localparam int CAPT_LSB  = 24;
  localparam int DEST_LSB  = 16;
  localparam int PIECE_LSB = 8;
  localparam int COLOR_BIT = 13;
  localparam int SRC_LSB   = 0;

  localparam logic [31:0] EMPTY_MOVE = 32'h0;

  localparam int LANE_U   = 0;
  localparam int LANE_D   = 1;
  localparam int LANE_L   = 2;
  localparam int LANE_R   = 3;
  localparam int LANE_UL  = 4;
  localparam int LANE_UR  = 5;
  localparam int LANE_DL  = 6;
  localparam int LANE_DR  = 7;
  localparam int LANE_UUL = 8;
  localparam int LANE_UUR = 9;
  localparam int LANE_LLU = 10;
  localparam int LANE_RRU = 11;
  localparam int LANE_DDL = 12;
  localparam int LANE_DDR = 13;
  localparam int LANE_LLD = 14;
  localparam int LANE_RRD = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_QUIET = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A lane carries a real move only if it names a piece of the side to move.
  function automatic logic lane_legal(input logic [31:0] w, input logic color);
    return (w[PIECE_LSB +: TYPE_W] != '0) && (w[COLOR_BIT] == color);
  endfunction

  // Colour bit of the captured piece is ignored; only its type matters.
  function automatic logic lane_capture(input logic [31:0] w);
    return w[CAPT_LSB +: TYPE_W] != '0;
  endfunction

endpackage

// File: rtl/move_prio_enc.sv
// move_prio_enc: 16-bit lowest-index priority encoder.
//   mask  : request bits
//   index : index of the lowest set bit (0 when none set)
//   found : at least one bit of mask is set
module move_prio_enc (
  input  logic [15:0] mask,
  output logic [3:0]  index,
  output logic        found
);

  always_comb begin
    index = 4'd0;
    found = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        index = i[3:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_queue.sv
// move_queue: snapshots 16 candidate move lanes, filters them by colour,
// then emits captures first and quiet moves second over a valid/ready port.
//   clk, clear       : clock, asynchronous active-high reset
//   enable           : advance when high, hold (and suppress valid) when low
//   engineColor      : side to move, sampled at load
//   moves_in, load   : 16 x 32-bit lane snapshot and its request
//   load_ready       : a load would be accepted this cycle
//   move_out/valid   : offered move word; move_ready accepts it
//   done             : one-cycle end-of-batch pulse
//   move_count       : moves emitted in the last or current batch
module move_queue
  import move_queue_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  engineColor,
  input  logic [LANES*32-1:0]   moves_in,
  input  logic                  load,
  output logic                  load_ready,
  output logic [31:0]           move_out,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic                  done,
  output logic [COUNT_W-1:0]    move_count
);

  state_t              state;
  logic [31:0]         lane_q [LANES];
  logic [LANES-1:0]    pending;
  logic [LANES-1:0]    legal_mask;
  logic [LANES-1:0]    cap_mask;
  logic [3:0]          cap_idx;
  logic [3:0]          pend_idx;
  logic                cap_found;
  logic                pend_found;
  logic [3:0]          sel_idx;

  // Count saturates at one full batch of lanes.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == COUNT_W'(LANES)) ? c : c + 1'b1;
  endfunction

  always_comb begin
    legal_mask = '0;
    cap_mask   = '0;
    for (int i = 0; i < LANES; i++) begin
      legal_mask[i] = lane_legal(moves_in[32*i +: 32], engineColor);
      cap_mask[i]   = pending[i] && lane_capture(lane_q[i]);
    end
  end

  move_prio_enc u_cap_enc (
    .mask  (cap_mask),
    .index (cap_idx),
    .found (cap_found)
  );

  move_prio_enc u_pend_enc (
    .mask  (pending),
    .index (pend_idx),
    .found (pend_found)
  );

  assign sel_idx    = (state == ST_CAPT) ? cap_idx : pend_idx;
  assign move_valid = enable && (((state == ST_CAPT) && cap_found) ||
                                 ((state == ST_QUIET) && pend_found));
  assign move_out   = move_valid ? lane_q[sel_idx] : EMPTY_MOVE;
  assign load_ready = (state == ST_IDLE) && enable;
  assign done       = (state == ST_DONE) && enable;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= ST_IDLE;
      pending    <= '0;
      move_count <= '0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= EMPTY_MOVE;
    end else if (enable) begin
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            for (int i = 0; i < LANES; i++) lane_q[i] <= moves_in[32*i +: 32];
            pending    <= legal_mask;
            move_count <= '0;
            state      <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (!cap_found) begin
            state <= ST_QUIET;
          end else if (move_ready) begin
            pending[cap_idx] <= 1'b0;
            move_count       <= sat_inc(move_count);
          end
        end
        ST_QUIET: begin
          if (!pend_found) begin
            state <= ST_DONE;
          end else if (move_ready) begin
            pending[pend_idx] <= 1'b0;
            move_count        <= sat_inc(move_count);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_queue.sv
// Scoreboard bench for move_queue: stimulus pushes expected move words and
// batch counts; a negedge monitor compares offered moves and done pulses.
module tb_move_queue;
  import move_queue_pkg::*;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         enable = 1'b1;
  logic         engineColor = 1'b0;
  logic [511:0] moves_in = '0;
  logic         load = 1'b0;
  logic         load_ready;
  logic [31:0]  move_out;
  logic         move_valid;
  logic         move_ready = 1'b1;
  logic         done;
  logic [4:0]   move_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  cnt_q[$];

  move_queue #(.LANES(16)) dut (
    .clk         (clk),
    .clear       (clear),
    .enable      (enable),
    .engineColor (engineColor),
    .moves_in    (moves_in),
    .load        (load),
    .load_ready  (load_ready),
    .move_out    (move_out),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .done        (done),
    .move_count  (move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] cap, input logic [5:0] dst,
                                     input logic [5:0] pc, input logic [5:0] src);
    return {2'b00, cap, 2'b00, dst, 2'b00, pc, 2'b00, src};
  endfunction

  // Monitor: every offered move must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!clear) begin
      if (move_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", move_out, EMPTY_MOVE);
          if (move_out === EMPTY_MOVE) begin
            failures++;
            $display("FAIL unexpected_valid actual=1 required=0");
          end
        end else begin
          chk("move_out", move_out, exp_q[0]);
          if (move_ready && enable) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        if (cnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          chk("done_move_count", {27'd0, move_count}, {27'd0, cnt_q.pop_front()});
        end
      end
    end
  end

  task automatic do_load(input logic color);
    @(posedge clk); #1;
    engineColor = color;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (n < bound && !move_valid) begin
      @(negedge clk);
      n++;
    end
    if (!move_valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout actual=0 required=1");
    end
  endtask

  initial begin
    int n;
    logic [31:0] w;

    // Reset state, sampled while clear is held.
    repeat (3) @(negedge clk);
    chk("rst_move_valid", {31'd0, move_valid}, 0);
    chk("rst_move_out", move_out, EMPTY_MOVE);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_move_count", {27'd0, move_count}, 0);
    chk("rst_load_ready", {31'd0, load_ready}, 1);
    @(posedge clk); #1;
    clear = 1'b0;

    // BLACK engine: capture lane6 first, then quiet lanes 1 and 9 in order.
    moves_in = '0;
    moves_in[32*LANE_D +: 32]   = mk(6'd0, 6'd20, {BLACK, ROOK}, 6'd4);
    moves_in[32*LANE_DL +: 32]  = mk({WHITE, PAWN}, 6'd30, {BLACK, KNIGHT}, 6'd40);
    w = mk(6'd0, 6'd12, {BLACK, BISHOP}, 6'd5) | 32'hC0C0C0C0;
    moves_in[32*LANE_UUR +: 32] = w;
    exp_q.push_back(moves_in[32*LANE_DL +: 32]);
    exp_q.push_back(moves_in[32*LANE_D +: 32]);
    exp_q.push_back(w);
    cnt_q.push_back(5'd3);
    move_ready = 1'b1;
    do_load(BLACK);
    wait_done(20, n);

    // Empty batch: no valid at all, done at load+3, count 0.
    moves_in = '0;
    cnt_q.push_back(5'd0);
    do_load(BLACK);
    wait_done(10, n);
    chk("empty_done_latency", n, 3);

    // Wrong colour and typeless lanes are discarded.
    moves_in = '0;
    moves_in[32*LANE_R +: 32]  = mk(6'd0, 6'd10, {WHITE, QUEEN}, 6'd2);
    moves_in[32*LANE_UR +: 32] = mk(6'd0, 6'd11, {BLACK, KING}, 6'd3);
    moves_in[32*LANE_DR +: 32] = mk({WHITE, PAWN}, 6'd9, 6'd0, 6'd1);
    exp_q.push_back(moves_in[32*LANE_UR +: 32]);
    cnt_q.push_back(5'd1);
    do_load(BLACK);
    wait_done(20, n);

    // Back-pressure on lane2, ignored load mid-batch, enable low hold.
    moves_in = '0;
    w = mk(6'd0, 6'd33, {WHITE, QUEEN}, 6'd17);
    moves_in[32*LANE_L +: 32] = w;
    exp_q.push_back(w);
    cnt_q.push_back(5'd1);
    move_ready = 1'b0;
    do_load(WHITE);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      load = (i == 1);
      if (i == 1) moves_in = {16{mk(6'd0, 6'd1, {WHITE, ROOK}, 6'd2)}};
      @(negedge clk);
      chk("hold_move_out", move_out, w);
      chk("hold_move_count", {27'd0, move_count}, 0);
    end
    @(posedge clk); #1;
    load = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("dis_move_valid", {31'd0, move_valid}, 0);
    chk("dis_load_ready", {31'd0, load_ready}, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    chk("dis_move_count", {27'd0, move_count}, 0);
    @(posedge clk); #1;
    move_ready = 1'b1;
    @(posedge clk); #1;
    move_ready = 1'b0;
    @(negedge clk);
    chk("release_move_count", {27'd0, move_count}, 1);
    wait_done(10, n);

    // Clear while the 2nd of 4 moves is offered.
    moves_in = '0;
    moves_in[32*LANE_U +: 32]   = mk(6'd0, 6'd1, {WHITE, PAWN}, 6'd8);
    moves_in[32*LANE_UL +: 32]  = mk(6'd0, 6'd2, {WHITE, KNIGHT}, 6'd9);
    moves_in[32*LANE_DR +: 32]  = mk(6'd0, 6'd3, {WHITE, BISHOP}, 6'd10);
    moves_in[32*LANE_DDL +: 32] = mk(6'd0, 6'd4, {WHITE, KING}, 6'd11);
    exp_q.push_back(moves_in[32*LANE_U +: 32]);
    exp_q.push_back(moves_in[32*LANE_UL +: 32]);
    exp_q.push_back(moves_in[32*LANE_DR +: 32]);
    exp_q.push_back(moves_in[32*LANE_DDL +: 32]);
    move_ready = 1'b0;
    do_load(WHITE);
    wait_valid(10);
    @(posedge clk); #1;
    move_ready = 1'b1;
    @(posedge clk); #1;
    move_ready = 1'b0;
    @(negedge clk);
    chk("mid_move_count", {27'd0, move_count}, 1);
    chk("mid_move_out", move_out, moves_in[32*LANE_UL +: 32]);
    @(posedge clk); #1;
    clear = 1'b1;
    exp_q.delete();
    #1;
    chk("clr_move_valid", {31'd0, move_valid}, 0);
    chk("clr_move_out", move_out, EMPTY_MOVE);
    chk("clr_move_count", {27'd0, move_count}, 0);
    chk("clr_done", {31'd0, done}, 0);
    #1;
    clear = 1'b0;
    @(negedge clk);
    chk("post_clr_load_ready", {31'd0, load_ready}, 1);
    repeat (4) @(negedge clk);
    moves_in = '0;
    moves_in[32*LANE_UUL +: 32] = mk(6'd0, 6'd5, {WHITE, ROOK}, 6'd12);
    exp_q.push_back(moves_in[32*LANE_UUL +: 32]);
    cnt_q.push_back(5'd1);
    move_ready = 1'b1;
    do_load(WHITE);
    wait_done(10, n);

    // All 16 lanes legal captures: emitted 0..15, load_ready low throughout.
    for (int i = 0; i < 16; i++) begin
      moves_in[32*i +: 32] = mk(6'(i + 1), 6'(i), {WHITE, PAWN}, 6'(63 - i));
      exp_q.push_back(moves_in[32*i +: 32]);
    end
    cnt_q.push_back(5'd16);
    do_load(WHITE);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      chk("batch_load_ready", {31'd0, load_ready}, 0);
      if (done) break;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL full_done_timeout actual=0 required=1");
    end
    chk("full_queue_drained", exp_q.size(), 0);
    chk("full_move_count", {27'd0, move_count}, 16);

    @(posedge clk); #1;
    @(negedge clk);
    chk("final_load_ready", {31'd0, load_ready}, 1);
    chk("final_count_hold", {27'd0, move_count}, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
